keypad_entry_ctrl: RTL and testbench

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

---
 rtl/keypad_entry_ctrl.sv | 140 ++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: collects up to MAX_DIGITS BCD digits from a keypad,
// supports clear/backspace/cancel/enter editing, and hands the completed entry
// to a consumer with a valid/ready handshake.
// Optional inactivity timeout is built when KEYPAD_ENTRY_TIMEOUT_EN is defined.
module keypad_entry_ctrl #(
  parameter int unsigned MAX_DIGITS  = 4,
  parameter int unsigned TIMEOUT_CYC = 32'd250_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_en,
  input  logic [3:0]  key_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_bcd,
  output logic [2:0]  out_len,
  output logic [15:0] disp_bcd,
  output logic [2:0]  disp_len,
  output logic        busy,
  output logic        abort
);

  typedef enum logic [1:0] {StIdle, StEntry, StHold} state_e;

  localparam logic [2:0] MaxLen    = 3'(MAX_DIGITS);
  localparam logic [3:0] KeyClear  = 4'hA;
  localparam logic [3:0] KeyBack   = 4'hB;
  localparam logic [3:0] KeyCancel = 4'hE;
  localparam logic [3:0] KeyEnter  = 4'hF;

  state_e state_q;
  logic   is_digit;
  logic   key_accept;
  logic   timeout_hit;

  // Decide whether the presented key changes anything; ignored keys touch nothing.
  always_comb begin
    is_digit   = (key_data <= 4'd9);
    key_accept = 1'b0;
    if (key_en && (state_q != StHold)) begin
      if (is_digit) begin
        key_accept = (disp_len < MaxLen);
      end else begin
        case (key_data)
          KeyClear, KeyCancel: key_accept = 1'b1;
          KeyBack, KeyEnter:   key_accept = (state_q == StEntry);
          default:             key_accept = 1'b0;
        endcase
      end
    end
  end

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  logic [31:0] timer_q;

  // Inactivity counter: runs only while an entry is open and no key is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else if ((state_q == StEntry) && !key_accept && !timeout_hit) begin
      timer_q <= timer_q + 32'd1;
    end else begin
      timer_q <= '0;
    end
  end

  // An accepted key on the expiry cycle wins over the timeout.
  assign timeout_hit = (state_q == StEntry) && !key_accept &&
                       (timer_q == 32'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  // Controller: buffer edits, entry handoff, abort pulse; every output is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_len   <= '0;
      disp_bcd  <= '0;
      disp_len  <= '0;
      busy      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      abort <= 1'b0;
      if (state_q == StHold) begin
        // Keys presented while holding (even on the handshake cycle) are dropped.
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
      end else if (key_accept) begin
        if (is_digit) begin
          disp_bcd <= {disp_bcd[11:0], key_data};
          disp_len <= disp_len + 3'd1;
          state_q  <= StEntry;
        end else begin
          case (key_data)
            KeyBack: begin
              disp_bcd <= {4'h0, disp_bcd[15:4]};
              disp_len <= disp_len - 3'd1;
              if (disp_len == 3'd1) state_q <= StIdle;
            end
            KeyEnter: begin
              out_bcd   <= disp_bcd;
              out_len   <= disp_len;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              disp_bcd  <= '0;
              disp_len  <= '0;
              state_q   <= StHold;
            end
            KeyCancel: begin
              disp_bcd <= '0;
              disp_len <= '0;
              abort    <= 1'b1;
              state_q  <= StIdle;
            end
            default: begin
              // Clear: same as cancel but silent.
              disp_bcd <= '0;
              disp_len <= '0;
              state_q  <= StIdle;
            end
          endcase
        end
      end else if (timeout_hit) begin
        disp_bcd <= '0;
        disp_len <= '0;
        abort    <= 1'b1;
        state_q  <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Testbench for keypad_entry_ctrl: directed scenarios plus random keys, checked
// against a digit-list reference model; completed entries go through a queue
// that an independent monitor drains on every handshake.
module tb_keypad_entry_ctrl;
  localparam int unsigned MaxDigits  = 4;
  localparam int unsigned TimeoutCyc = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_en;
  logic [3:0]  key_data;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_bcd;
  logic [2:0]  out_len;
  logic [15:0] disp_bcd;
  logic [2:0]  disp_len;
  logic        busy;
  logic        abort;

  keypad_entry_ctrl #(
    .MAX_DIGITS (MaxDigits),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_en   (key_en),
    .key_data (key_data),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_bcd  (out_bcd),
    .out_len  (out_len),
    .disp_bcd (disp_bcd),
    .disp_len (disp_len),
    .busy     (busy),
    .abort    (abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bcd;
    logic [2:0]  len;
  } entry_t;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: typed digits in order (oldest first), plus hold status.
  int          digits[$];
  bit          hold      = 1'b0;
  logic [15:0] last_bcd  = '0;
  logic [2:0]  last_len  = '0;
  bit          exp_abort = 1'b0;
  int          idle_cnt  = 0;
  entry_t      exp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd();
    logic [15:0] v = '0;
    foreach (digits[i]) v = {v[11:0], 4'(digits[i])};
    return v;
  endfunction

  task automatic model(bit r, bit en, logic [3:0] k, bit rdy);
    bit in_entry;
    bit acc;
    exp_abort = 1'b0;
    if (r) begin
      digits.delete();
      if (hold) void'(exp_q.pop_back());
      hold     = 1'b0;
      last_bcd = '0;
      last_len = '0;
      idle_cnt = 0;
      return;
    end
    in_entry = !hold && (digits.size() > 0);
    acc      = 1'b0;
    if (hold) begin
      if (rdy) hold = 1'b0;
    end else if (en) begin
      if (k <= 4'd9) begin
        if (digits.size() < MaxDigits) begin
          digits.push_back(int'(k));
          acc = 1'b1;
        end
      end else if (k == 4'hA) begin
        digits.delete();
        acc = 1'b1;
      end else if (k == 4'hB) begin
        if (in_entry) begin
          void'(digits.pop_back());
          acc = 1'b1;
        end
      end else if (k == 4'hE) begin
        digits.delete();
        exp_abort = 1'b1;
        acc       = 1'b1;
      end else if (k == 4'hF) begin
        if (in_entry) begin
          last_bcd = to_bcd();
          last_len = 3'(digits.size());
          exp_q.push_back({last_bcd, last_len});
          digits.delete();
          hold = 1'b1;
          acc  = 1'b1;
        end
      end
    end
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    if (in_entry && !acc && (idle_cnt == int'(TimeoutCyc) - 1)) begin
      digits.delete();
      exp_abort = 1'b1;
      acc       = 1'b1;
    end
`endif
    if (in_entry && !acc) idle_cnt++;
    else idle_cnt = 0;
  endtask

  task automatic step(bit r, bit en, logic [3:0] k, bit rdy);
    rst       = r;
    key_en    = en;
    key_data  = k;
    out_ready = rdy;
    model(r, en, k, rdy);
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(hold));
    check("busy", 32'(busy), 32'(hold));
    check("abort", 32'(abort), 32'(exp_abort));
    check("disp_bcd", 32'(disp_bcd), 32'(to_bcd()));
    check("disp_len", 32'(disp_len), 32'(digits.size()));
    check("out_bcd", 32'(out_bcd), 32'(last_bcd));
    check("out_len", 32'(out_len), 32'(last_len));
  endtask

  task automatic press(logic [3:0] k, bit rdy);
    step(1'b0, 1'b1, k, rdy);
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, rdy);
  endtask

  // Monitor: on every handshake, pop the oldest expected entry and compare.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL handshake: got entry %h/%0d, expected none pending", out_bcd, out_len);
        end else begin
          e = exp_q.pop_front();
          check("hs_bcd", 32'(out_bcd), 32'(e.bcd));
          check("hs_len", 32'(out_len), 32'(e.len));
        end
      end
    end
  end

  initial begin
    logic [3:0] k;
    step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 1'b0);

    // 1,2,3,F with ready high: one-cycle valid, 0123 / 3
    press(4'h1, 1'b1); press(4'h2, 1'b1); press(4'h3, 1'b1); press(4'hF, 1'b1);
    idle(2, 1'b1);

    // 9,8,7,6,5,F: fifth digit dropped
    press(4'h9, 1'b1); press(4'h8, 1'b1); press(4'h7, 1'b1); press(4'h6, 1'b1);
    press(4'h5, 1'b1); press(4'hF, 1'b1);
    idle(2, 1'b1);

    // 4,5,B,B,B then F in idle: nothing produced
    press(4'h4, 1'b1); press(4'h5, 1'b1);
    press(4'hB, 1'b1); press(4'hB, 1'b1); press(4'hB, 1'b1);
    press(4'hF, 1'b1);
    idle(2, 1'b1);

    // 7,F held for 10 cycles, key 3 during the hold ignored, then release
    press(4'h7, 1'b0); press(4'hF, 1'b0);
    idle(3, 1'b0);
    press(4'h3, 1'b0);
    idle(6, 1'b0);
    press(4'h3, 1'b1);
    idle(2, 1'b0);

    // C/D ignored, E in idle pulses abort, A clears silently
    press(4'hC, 1'b0); press(4'hD, 1'b0); press(4'hE, 1'b0);
    press(4'h2, 1'b0); press(4'hA, 1'b0); idle(1, 1'b0);

    // 1,2 then reset with E pressed: everything zero, no abort
    press(4'h1, 1'b0); press(4'h2, 1'b0);
    step(1'b1, 1'b1, 4'hE, 1'b1);
    idle(2, 1'b0);

    // reset while holding
    press(4'h8, 1'b0); press(4'hF, 1'b0); idle(1, 1'b0);
    step(1'b1, 1'b0, 4'h0, 1'b1);
    idle(1, 1'b1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 6) k = 4'($urandom_range(0, 9));
      else k = 4'($urandom_range(10, 15));
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), k,
           ($urandom_range(0, 3) != 0));
    end

    idle(3, 1'b1);
    check("pending_entries", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
